cart_bank_ctrl: RTL and testbench
=================================

# cart_bank_ctrl

Cartridge bus controller for the Atari 2600 top level. It sits between the 6507 address/data bus and an external, variable-latency ROM. It sequences each cartridge fetch through a request/acknowledge handshake and stalls the CPU through RDY until the data is available. It also implements Atari F8/F6/F4 bank switching and, optionally, SuperChip on-cartridge RAM.

## Interface
Parameters:
- BANKS, 2, number of 4 KiB banks. Only 2 (F8), 4 (F6) or 8 (F4) are legal; any other value is an elaboration error.

Ports:
- MCLK  in  1  machine clock; all state changes on the rising edge.
- RES  in  1  reset, synchronous, active-high.
- A  in  13  CPU address A12..A0.
- R_W  in  1  read(1)/write(0).
- D_IN  in  8  CPU write data.
- D_OUT  out  8  cartridge read data to the CPU bus mux.
- RDY  out  1  stall request; ANDed with TIA RDY at top level.
- MEM_REQ  out  1  external ROM read request.
- MEM_ADDR  out  15  external ROM address, {bank[2:0], A[11:0]}.
- MEM_ACK  in  1  single-cycle data-valid pulse.
- MEM_DATA  in  8  ROM data, valid when MEM_ACK=1.
- BANK  out  3  current bank; upper bits are zero when BANKS<8.

## Operation
- Cartridge access: A[12]=1. Non-cartridge access: RDY=1, D_OUT=8'h00, no state change.
- FSM states:
  - IDLE → FETCH on a cartridge read that does not hit SuperChip.
  - FETCH → DONE on MEM_ACK.
  - DONE → IDLE unconditionally.
- IDLE:
  - On a cartridge read (not SuperChip): RDY=0 combinationally in the same cycle.
  - In FETCH and DONE, RDY is driven by the state (see below).
- FETCH:
  - MEM_REQ=1, RDY=0.
  - MEM_ADDR is held constant; the bank is frozen.
  - On MEM_ACK, MEM_DATA is captured into the data latch.
- DONE:
  - RDY=1 and D_OUT = data latch, for exactly one cycle.
- Writes to cartridge space never stall and never raise MEM_REQ.
- Hotspots (read or write), with bank n given by the offset from the first hotspot:
  - F8: 1FF8–1FF9.
  - F6: 1FF6–1FF9.
  - F4: 1FF4–1FFB.
- Hotspot effect:
  - A hotspot read returns data from the old bank; BANK updates on the DONE→IDLE edge.
  - A hotspot write updates BANK at the end of the write cycle.
  - Each access switches the bank exactly once, even though the address is held during a stall.
- BANK is used for MEM_ADDR[14:12].
- MEM_ACK outside FETCH is ignored.
- Reset:
  - BANK = BANKS-1, state = IDLE, MEM_REQ=0, D_OUT=8'h00, data latch = 8'h00.
  - RES asserted during FETCH aborts the fetch. MEM_REQ=0 in the next cycle, and a later ACK is discarded.
- Address changing during FETCH is a CPU protocol violation; the block keeps the captured MEM_ADDR.

## Timing
- Read latency:
  - Address in cycle 0 (RDY=0). MEM_REQ rises at the cycle-1 edge.
  - ACK in cycle k≥1 → DONE in cycle k+1 → IDLE in k+2.
  - Minimum 2 stall cycles.
- MEM_REQ deasserts on the edge following the ACK cycle.
- Back-to-back reads: a new fetch can start in the cycle after DONE.
- SuperChip hits and writes complete in 1 cycle with RDY=1.

## Configuration
- SUPERCHIP_EN defined:
  - 128×8 RAM.
  - Writes at 1000–107F (R_W=0), reads at 1080–10FF, zero latency. D_OUT is the asynchronous array read; no MEM_REQ.
  - A read of the write port or a write to the read port is ignored; the read returns 8'h00.
  - RAM contents are not cleared by RES.
- SUPERCHIP_EN undefined: these addresses are ordinary ROM and follow the FSM.

## Structure
- cart_pkg:
  - state encoding (IDLE, FETCH, DONE);
  - hotspot base constants per BANKS value;
  - SuperChip window constants.
- One sub-module: cart_sc_ram (128×8, synchronous write, asynchronous read), instantiated only under SUPERCHIP_EN.

## Test plan
- Reset, BANKS=2: BANK=1, RDY=1, MEM_REQ=0. Read A=13'h1000 with ACK 3 cycles later and MEM_DATA=8'hA5 → MEM_ADDR=15'h1000, RDY=0 for 4 cycles, then D_OUT=8'hA5 with RDY=1.
- BANKS=4: read 1FF7 → data from bank 3 address 3FF7, then BANK=1. The next read of 1000 → MEM_ADDR=15'h1000.
- BANKS=8: write 1FFB with R_W=0 → RDY stays 1, no MEM_REQ, BANK=7 on the next cycle.
- RES pulsed mid-FETCH, then ACK arrives 2 cycles later → MEM_REQ low after RES, state IDLE, BANK=BANKS-1, ACK ignored.
- SUPERCHIP_EN: write 8'h3C to 1005, then read 1085 → D_OUT=8'h3C in the same cycle, RDY=1, no MEM_REQ. Without the macro the same read issues MEM_REQ.
- A=13'h0080 (RIOT) read → RDY=1, D_OUT=8'h00, no MEM_REQ.

Source files
------------

// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge bus controller: FSM encoding,
// bank-switch hotspot bases and the SuperChip RAM window.
// Pure declarations; no logic, no latency, no flow control.
package cart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } cart_state_t;

    // First hotspot offset (A[11:0]) per scheme; hotspot n selects bank n.
    localparam logic [11:0] HS_BASE_F8 = 12'hFF8;
    localparam logic [11:0] HS_BASE_F6 = 12'hFF6;
    localparam logic [11:0] HS_BASE_F4 = 12'hFF4;

    // SuperChip occupies 1000-10FF: A[7]=0 is the write port, A[7]=1 the read port.
    localparam logic [4:0] SC_PAGE  = 5'h10;
    localparam int         SC_DEPTH = 128;
    localparam int         SC_AW    = 7;

    function automatic logic [11:0] hs_base(input int banks);
        case (banks)
            2:       return HS_BASE_F8;
            4:       return HS_BASE_F6;
            default: return HS_BASE_F4;
        endcase
    endfunction

endpackage

// File: rtl/cart_sc_ram.sv
// SuperChip on-cartridge RAM, 128x8.
// Write commits at the clock edge; read is combinational (zero latency).
// No backpressure: every enabled write is accepted.
module cart_sc_ram
    import cart_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [SC_AW-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [SC_AW-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [7:0] mem [SC_DEPTH];

    // Contents deliberately survive reset, like the real cartridge RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cart_bank_ctrl.sv
// Cartridge bus controller: ROM fetch handshake, F8/F6/F4 banking, optional SuperChip (SUPERCHIP_EN).
// Latency: cartridge read stalls from the address cycle until the cycle after MEM_ACK (>=2 stalls).
// Backpressure: RDY low stalls the CPU while the external ROM has not acknowledged.
module cart_bank_ctrl
    import cart_pkg::*;
#(
    parameter int BANKS = 2
) (
    input  logic        MCLK,
    input  logic        RES,
    input  logic [12:0] A,
    input  logic        R_W,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        RDY,
    output logic        MEM_REQ,
    output logic [14:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [7:0]  MEM_DATA,
    output logic [2:0]  BANK
);

    if (BANKS != 2 && BANKS != 4 && BANKS != 8) begin : g_bad_banks
        $error("cart_bank_ctrl: BANKS must be 2, 4 or 8");
    end

    localparam logic [11:0] HS_BASE = hs_base(BANKS);
    localparam logic [11:0] HS_LAST = HS_BASE + 12'(BANKS - 1);

    cart_state_t state;
    logic [2:0]  bank_q;
    logic [2:0]  pend_bank;
    logic        pend_vld;
    logic [7:0]  data_q;

    logic        cart_sel;
    logic        hs_hit;
    logic [2:0]  hs_bank;
    logic        sc_win;
    logic        sc_rd;
    logic [7:0]  sc_rdata;
    logic        rom_rd;

    assign cart_sel = A[12];
    assign hs_hit   = cart_sel && (A[11:0] >= HS_BASE) && (A[11:0] <= HS_LAST);
    // Offset from the first hotspot is always < 8, so three bits suffice.
    assign hs_bank  = A[2:0] - HS_BASE[2:0];

`ifdef SUPERCHIP_EN
    logic sc_wr;

    assign sc_win = (A[12:8] == SC_PAGE);
    assign sc_wr  = sc_win && !R_W && !A[7];
    assign sc_rd  = sc_win && R_W && A[7];

    cart_sc_ram u_sc_ram (
        .clk   (MCLK),
        .we    (sc_wr && (state == ST_IDLE)),
        .waddr (A[6:0]),
        .wdata (D_IN),
        .raddr (A[6:0]),
        .rdata (sc_rdata)
    );
`else
    logic unused_d_in;

    assign unused_d_in = ^D_IN;
    assign sc_win      = 1'b0;
    assign sc_rd       = 1'b0;
    assign sc_rdata    = 8'h00;
`endif

    // A cartridge read that must go out to the external ROM.
    assign rom_rd = cart_sel && R_W && !sc_win;

    assign BANK = bank_q;

    // Fetch sequencer; a hotspot read defers its bank change to DONE->IDLE so the data comes from the old bank.
    always_ff @(posedge MCLK) begin
        if (RES) begin
            state     <= ST_IDLE;
            MEM_REQ   <= 1'b0;
            MEM_ADDR  <= '0;
            data_q    <= 8'h00;
            bank_q    <= 3'(BANKS - 1);
            pend_bank <= '0;
            pend_vld  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rom_rd) begin
                        state     <= ST_FETCH;
                        MEM_REQ   <= 1'b1;
                        MEM_ADDR  <= {bank_q, A[11:0]};
                        pend_vld  <= hs_hit;
                        pend_bank <= hs_bank;
                    end else if (cart_sel && !R_W && hs_hit) begin
                        bank_q <= hs_bank;
                    end
                end
                ST_FETCH: begin
                    if (MEM_ACK) begin
                        data_q  <= MEM_DATA;
                        MEM_REQ <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (pend_vld) begin
                        bank_q   <= pend_bank;
                        pend_vld <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    MEM_REQ <= 1'b0;
                end
            endcase
        end
    end

    // CPU-facing stall and read-data mux; the IDLE stall is combinational so the address cycle itself stalls.
    always_comb begin
        RDY   = 1'b1;
        D_OUT = 8'h00;
        case (state)
            ST_IDLE: begin
                if (rom_rd) begin
                    RDY = 1'b0;
                end else if (sc_rd) begin
                    D_OUT = sc_rdata;
                end
            end
            ST_FETCH: RDY = 1'b0;
            ST_DONE:  D_OUT = data_q;
            default:  RDY = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_cart_bank_ctrl.sv
// Directed bench for cart_bank_ctrl with F8, F6 and F4 instances driven in parallel.
// Read data is queued when the ROM ack is driven and compared when RDY returns.
// ROM latency is controlled by the bench through MEM_ACK timing.
module tb_cart_bank_ctrl;

    logic        MCLK;
    logic        RES;
    logic [12:0] A;
    logic        R_W;
    logic [7:0]  D_IN;
    logic        MEM_ACK;
    logic [7:0]  MEM_DATA;

    logic [7:0]  d_out    [3];
    logic        rdy      [3];
    logic        mem_req  [3];
    logic [14:0] mem_addr [3];
    logic [2:0]  bank     [3];

    int total = 0;
    int bad   = 0;
    int exp_bank [3];
    logic [7:0] sb_q [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cart_bank_ctrl #(.BANKS(2 << g)) u_dut (
            .MCLK     (MCLK),
            .RES      (RES),
            .A        (A),
            .R_W      (R_W),
            .D_IN     (D_IN),
            .D_OUT    (d_out[g]),
            .RDY      (rdy[g]),
            .MEM_REQ  (mem_req[g]),
            .MEM_ADDR (mem_addr[g]),
            .MEM_ACK  (MEM_ACK),
            .MEM_DATA (MEM_DATA),
            .BANK     (bank[g])
        );
    end

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s[banks=%0d] got=%0h required=%0h", tag, 2 << inst, got, exp);
        end
    endtask

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    // Reference hotspot decode straight from the scheme tables.
    function automatic void hs_model(input int banks, input logic [12:0] a, output bit hit, output int nb);
        int base;
        int off;
        base = (banks == 2) ? 'hFF8 : (banks == 4) ? 'hFF6 : 'hFF4;
        off  = int'(a[11:0]);
        hit  = a[12] && (off >= base) && (off < base + banks);
        nb   = off - base;
    endfunction

    task automatic do_read(input logic [12:0] addr, input int k, input logic [7:0] data);
        int stall;
        int n;
        bit hit;
        int nb;
        logic [7:0]  exp_d;
        logic [14:0] ea;
        step();
        A = addr; R_W = 1'b1; MEM_ACK = 1'b0;
        #1;
        sb_q.push_back(data);
        stall = 0;
        for (int i = 0; i < 3; i++) begin
            chk("bank_before_read", i, 32'(bank[i]), 32'(exp_bank[i]));
            chk("rdy_addr_cycle", i, 32'(rdy[i]), 32'd0);
        end
        if (rdy[0] === 1'b0) stall++;
        for (int c = 1; c <= k; c++) begin
            step();
            if (c == k) begin
                MEM_ACK = 1'b1;
                MEM_DATA = data;
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                ea = {3'(exp_bank[i]), addr[11:0]};
                chk("mem_req_fetch", i, 32'(mem_req[i]), 32'd1);
                chk("mem_addr", i, 32'(mem_addr[i]), 32'(ea));
            end
            if (rdy[0] === 1'b0) stall++;
        end
        step();
        MEM_ACK = 1'b0; MEM_DATA = 8'h00;
        #1;
        n = 0;
        while (rdy[0] !== 1'b1 && n < 8) begin
            step();
            #1;
            n++;
        end
        chk("done_wait_cycles", 0, 32'(n), 32'd0);
        exp_d = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            chk("done_rdy", i, 32'(rdy[i]), 32'd1);
            chk("done_dout", i, 32'(d_out[i]), 32'(exp_d));
            chk("done_mem_req", i, 32'(mem_req[i]), 32'd0);
            hs_model(2 << i, addr, hit, nb);
            if (hit) exp_bank[i] = nb;
        end
        chk("stall_cycles", 0, 32'(stall), 32'(k + 1));
    endtask

    task automatic do_write(input logic [12:0] addr, input logic [7:0] data);
        bit hit;
        int nb;
        step();
        A = addr; R_W = 1'b0; D_IN = data;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("write_rdy", i, 32'(rdy[i]), 32'd1);
            chk("write_mem_req", i, 32'(mem_req[i]), 32'd0);
            hs_model(2 << i, addr, hit, nb);
            if (hit) exp_bank[i] = nb;
        end
        step();
        A = 13'h0080; R_W = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("after_write_mem_req", i, 32'(mem_req[i]), 32'd0);
            chk("after_write_bank", i, 32'(bank[i]), 32'(exp_bank[i]));
        end
    endtask

    initial begin
        RES = 1'b1; A = 13'h0080; R_W = 1'b1; D_IN = 8'h00;
        MEM_ACK = 1'b0; MEM_DATA = 8'h00;
        for (int i = 0; i < 3; i++) exp_bank[i] = (2 << i) - 1;
        repeat (3) @(posedge MCLK);
        #1;
        RES = 1'b0;
        #1;

        // Reset state.
        for (int i = 0; i < 3; i++) begin
            chk("reset_bank", i, 32'(bank[i]), 32'(exp_bank[i]));
            chk("reset_rdy", i, 32'(rdy[i]), 32'd1);
            chk("reset_mem_req", i, 32'(mem_req[i]), 32'd0);
            chk("reset_dout", i, 32'(d_out[i]), 32'd0);
        end

        // RIOT access is outside cartridge space.
        step();
        A = 13'h0080; R_W = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("riot_rdy", i, 32'(rdy[i]), 32'd1);
            chk("riot_dout", i, 32'(d_out[i]), 32'd0);
        end
        step();
        for (int i = 0; i < 3; i++) chk("riot_mem_req", i, 32'(mem_req[i]), 32'd0);

        // Plain read, ack three cycles after the address.
        do_read(13'h1000, 3, 8'hA5);
        // Hotspot read: data from old bank, bank moves afterwards.
        do_read(13'h1FF7, 1, 8'h5A);
        // Back-to-back read sees the new bank.
        do_read(13'h1000, 2, 8'hC7);

        // Hotspot writes switch banks without stalling.
        do_write(13'h1FFB, 8'h00);
        do_write(13'h1FF8, 8'h00);

        // Reset in the middle of a fetch; the late ack must be discarded.
        step();
        A = 13'h1234; R_W = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk("abort_rdy0", i, 32'(rdy[i]), 32'd0);
        step();
        for (int i = 0; i < 3; i++) chk("abort_mem_req_fetch", i, 32'(mem_req[i]), 32'd1);
        step();
        RES = 1'b1;
        step();
        RES = 1'b0; A = 13'h0080;
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_bank[i] = (2 << i) - 1;
            chk("abort_mem_req", i, 32'(mem_req[i]), 32'd0);
            chk("abort_rdy", i, 32'(rdy[i]), 32'd1);
            chk("abort_bank", i, 32'(bank[i]), 32'(exp_bank[i]));
        end
        step();
        MEM_ACK = 1'b1; MEM_DATA = 8'hC3;
        #1;
        for (int i = 0; i < 3; i++) chk("stray_ack_mem_req", i, 32'(mem_req[i]), 32'd0);
        step();
        MEM_ACK = 1'b0; MEM_DATA = 8'h00;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stray_ack_rdy", i, 32'(rdy[i]), 32'd1);
            chk("stray_ack_dout", i, 32'(d_out[i]), 32'd0);
        end

        // SuperChip window.
        do_write(13'h1005, 8'h3C);
`ifdef SUPERCHIP_EN
        step();
        A = 13'h1085; R_W = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("sc_rdy", i, 32'(rdy[i]), 32'd1);
            chk("sc_dout", i, 32'(d_out[i]), 32'h3C);
            chk("sc_mem_req", i, 32'(mem_req[i]), 32'd0);
        end
        step();
        A = 13'h1005; R_W = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("sc_wrport_read_rdy", i, 32'(rdy[i]), 32'd1);
            chk("sc_wrport_read_dout", i, 32'(d_out[i]), 32'd0);
            chk("sc_wrport_read_req", i, 32'(mem_req[i]), 32'd0);
        end
`else
        do_read(13'h1085, 1, 8'h77);
`endif

        // Non-cartridge read after everything else.
        step();
        A = 13'h0080; R_W = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("final_riot_rdy", i, 32'(rdy[i]), 32'd1);
            chk("final_riot_dout", i, 32'(d_out[i]), 32'd0);
        end
        step();
        for (int i = 0; i < 3; i++) chk("final_riot_mem_req", i, 32'(mem_req[i]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
